// File: rtl/sb_rx.sv
`default_nettype none
// ============================================================================
// Module      : sb_rx
// Description : Sideband receive deserializer. Samples the serial sideband
//               lane while the forwarded clock is active and rebuilds 64-bit
//               packets, LSB first. After each packet it checks the
//               mandatory low-data inter-packet gap. Completed packets are
//               buffered in a small FIFO that is drained via valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_rx #(
    parameter int buffer_size = 4,   // FIFO depth in packets (power of 2, >1)
    parameter int GAP_CYCLES  = 32   // required gap length, 1..64
) (
    input  logic        clk_800MHz,
    input  logic        reset,        // asynchronous, active-low
    input  logic        dataPin_i,
    input  logic        clkActive_i,
    input  logic        enable_i,
    output logic [63:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        overflow_o,
    output logic        frame_err_o,
    output logic        gap_err_o,
    input  logic        err_clr_i
);

    localparam int         c_AW       = $clog2(buffer_size);
    localparam logic [6:0] c_GAP_LAST = 7'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_bit_ctr;
    logic [6:0]  r_gap_ctr;
    logic [63:0] r_shift;
    logic        r_push_pend;
    logic        r_frame_err;
    logic        r_overflow;
    logic        r_gap_err;

    logic [63:0]   r_mem [buffer_size];
    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;

    logic w_capture;
    logic w_complete;
    logic w_frame_err;
    logic w_gap_tick;
    logic w_gap_bad;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // State register
    always_ff @(posedge clk_800MHz or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle framing events
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_complete  = 1'b0;
        w_frame_err = 1'b0;
        w_gap_tick  = 1'b0;
        w_gap_bad   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable_i && clkActive_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RECV;
                end
            end
            S_RECV: begin
                if (!enable_i || !clkActive_i) begin
                    // Entered from a completed gap but no bit 0 arrived:
                    // nothing partial to discard, so return quietly.
                    w_frame_err = (r_bit_ctr != 6'd0);
                    w_state_nxt = S_IDLE;
                end else begin
                    w_capture = 1'b1;
                    if (r_bit_ctr == 6'd63) begin
                        w_complete  = 1'b1;
                        w_state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (!enable_i || !clkActive_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_tick = 1'b1;
                    w_gap_bad  = dataPin_i;
                    if (r_gap_ctr == c_GAP_LAST) begin
                        w_state_nxt = S_RECV;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bit/gap counters, shift register and push request
    always_ff @(posedge clk_800MHz or negedge reset) begin
        if (!reset) begin
            r_bit_ctr   <= 6'd0;
            r_gap_ctr   <= 7'd0;
            r_shift     <= 64'd0;
            r_push_pend <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_state_nxt == S_IDLE) begin
                r_bit_ctr <= 6'd0;
            end else if (w_capture) begin
                r_bit_ctr <= r_bit_ctr + 6'd1;
            end
            if (w_capture) begin
                r_shift[r_bit_ctr] <= dataPin_i;
            end
            r_gap_ctr <= (w_gap_tick && w_state_nxt == S_GAP) ? r_gap_ctr + 7'd1 : 7'd0;
            // The push reads r_shift directly: the cycle after completion is
            // always a gap cycle, so no capture can overwrite it first.
            r_push_pend <= w_complete;
            r_frame_err <= w_frame_err;
        end
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop   = !w_empty && ready_i;
    assign w_push  = r_push_pend && (!w_full || w_pop);
    assign w_drop  = r_push_pend && w_full && !w_pop;

    // FIFO storage and pointers
    always_ff @(posedge clk_800MHz or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < buffer_size; i++) begin
                r_mem[i] <= 64'd0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= r_shift;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Sticky error flags; a new event wins over a clear in the same cycle
    always_ff @(posedge clk_800MHz or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_gap_err  <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (err_clr_i) begin
                r_overflow <= 1'b0;
            end
            if (w_gap_bad) begin
                r_gap_err <= 1'b1;
            end else if (err_clr_i) begin
                r_gap_err <= 1'b0;
            end
        end
    end

    assign data_o      = r_mem[r_rd_ptr[c_AW-1:0]];
    assign valid_o     = !w_empty;
    assign overflow_o  = r_overflow;
    assign frame_err_o = r_frame_err;
    assign gap_err_o   = r_gap_err;

endmodule
`default_nettype wire

// File: tb/tb_sb_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sb_rx
// Description : Self-checking bench for sb_rx. Stimulus pushes expected
//               packets into a scoreboard queue; a monitor pops and compares
//               on every accepted FIFO transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sb_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        dataPin;
    logic        clkActive;
    logic        enable;
    logic        ready;
    logic        err_clr;
    logic [63:0] data;
    logic        valid;
    logic        overflow;
    logic        frame_err;
    logic        gap_err;

    int          checks = 0;
    int          errors = 0;
    int          n_pop  = 0;
    int          fe_hi  = 0;
    logic [63:0] exp_q [$];
    logic [63:0] mon_exp;

    localparam logic [63:0] c_P1 = 64'hDEADBEEF_01234567;
    localparam logic [63:0] c_A5 = 64'hA5A5A5A5_A5A5A5A5;
    localparam logic [63:0] c_P5 = 64'h0F1E2D3C_4B5A6978;
    localparam logic [63:0] c_P6 = 64'h13579BDF_02468ACE;
    localparam logic [63:0] c_PR = 64'h89ABCDEF_76543210;
    localparam logic [63:0] c_F  = 64'hFFFFFFFF_FFFFFFFF;

    sb_rx #(.buffer_size(4), .GAP_CYCLES(32)) dut (
        .clk_800MHz (clk),
        .reset      (reset),
        .dataPin_i  (dataPin),
        .clkActive_i(clkActive),
        .enable_i   (enable),
        .data_o     (data),
        .valid_o    (valid),
        .ready_i    (ready),
        .overflow_o (overflow),
        .frame_err_o(frame_err),
        .gap_err_o  (gap_err),
        .err_clr_i  (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare every accepted transfer against the queue
    always @(negedge clk) begin
        if (reset === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got %h expected no transfer", data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("pop_data", data, mon_exp);
            end
            n_pop++;
        end
        if (frame_err === 1'b1) fe_hi++;
    end

    initial begin
        #100us;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic cyc(input logic ca, input logic d);
        clkActive = ca;
        dataPin   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [63:0] p, input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, p[i]);
    endtask

    task automatic gap(input int bad);
        for (int i = 0; i < 32; i++) cyc(1'b1, (i == bad));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    initial begin
        int          fe0;
        int          p0;
        logic [63:0] p;

        reset = 1'b0; dataPin = 1'b0; clkActive = 1'b0;
        enable = 1'b1; ready = 1'b1; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_gap_err", gap_err, 0);
        reset = 1'b1;
        idle(2);

        // Single packet and latency
        fe0 = fe_hi; p0 = n_pop;
        send_bits(c_P1, 64);
        exp_q.push_back(c_P1);
        chk("lat_c1_valid", valid, 0);
        cyc(1'b1, 1'b0);
        chk("lat_c2_valid", valid, 1);
        chk("t1_data", data, c_P1);
        for (int i = 1; i < 32; i++) cyc(1'b1, 1'b0);
        idle(2);
        chk("t1_pops", n_pop - p0, 1);
        chk("t1_overflow", overflow, 0);
        chk("t1_gap_err", gap_err, 0);
        chk("t1_frame_err_cnt", fe_hi - fe0, 0);

        // Back-to-back packets with exact gaps
        p0 = n_pop;
        for (int k = 1; k <= 3; k++) begin
            p = 64'(k);
            send_bits(p, 64);
            exp_q.push_back(p);
            gap(-1);
        end
        idle(3);
        chk("t2_pops", n_pop - p0, 3);
        chk("t2_gap_err", gap_err, 0);
        chk("t2_q_empty", exp_q.size(), 0);

        // Overflow: five packets into a four-deep FIFO
        ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            p = 64'hC0DE0000_00000000 | 64'(k);
            send_bits(p, 64);
            if (k <= 4) exp_q.push_back(p);
            gap(-1);
        end
        idle(2);
        chk("t3_overflow", overflow, 1);
        chk("t3_valid", valid, 1);
        p0 = n_pop;
        ready = 1'b1;
        idle(8);
        chk("t3_pops", n_pop - p0, 4);
        chk("t3_valid_drained", valid, 0);
        err_clr = 1'b1;
        cyc(1'b0, 1'b0);
        err_clr = 1'b0;
        chk("t3_overflow_clr", overflow, 0);

        // Truncated frame after 40 bits
        fe0 = fe_hi;
        send_bits(c_A5, 40);
        idle(3);
        chk("t4_fe_pulse_cycles", fe_hi - fe0, 1);
        chk("t4_fe_low", frame_err, 0);
        chk("t4_fifo_unchanged", valid, 0);
        send_bits(c_A5, 64);
        exp_q.push_back(c_A5);
        gap(-1);
        idle(3);
        chk("t4_q_empty", exp_q.size(), 0);
        chk("t4_fe_no_more", fe_hi - fe0, 1);

        // Gap violation on gap cycle 10
        send_bits(c_P5, 64);
        exp_q.push_back(c_P5);
        gap(10);
        idle(2);
        chk("t5_gap_err", gap_err, 1);
        idle(5);
        chk("t5_gap_err_sticky", gap_err, 1);
        chk("t5_q_empty", exp_q.size(), 0);
        ready = 1'b0;
        send_bits(c_P6, 64);
        exp_q.push_back(c_P6);
        gap(-1);
        idle(2);
        chk("t5_next_valid", valid, 1);
        chk("t5_next_data", data, c_P6);

        // Asynchronous reset in the middle of a packet
        send_bits(c_PR, 20);
        #2;
        reset = 1'b0;
        clkActive = 1'b0;
        dataPin = 1'b0;
        #1;
        chk("t6_valid", valid, 0);
        chk("t6_data", data, 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_gap_err", gap_err, 0);
        chk("t6_frame_err", frame_err, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        fe0 = fe_hi;
        idle(2);
        ready = 1'b1;
        p0 = n_pop;
        send_bits(c_F, 64);
        exp_q.push_back(c_F);
        gap(-1);
        idle(3);
        chk("t6_pops", n_pop - p0, 1);
        chk("t6_no_frame_err", fe_hi - fe0, 0);
        chk("t6_gap_err_after", gap_err, 0);

        chk("final_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sb_rx.md
Name: sb_rx

Overview:
Sideband receive deserializer that sits directly downstream of the sideband serializer. It samples the single-bit sideband data lane together with a level-form clock-activity indicator, reassembles 64-bit packets (LSB first), and checks the mandatory 32-cycle inter-packet gap. Completed packets go into a small FIFO, which the sideband protocol/decoder layer drains through a valid/ready handshake.

Parameters:
buffer_size, 4, FIFO depth in 64-bit packets; must be a power of 2 and >1
GAP_CYCLES, 32, required low-data cycles after each packet; range 1..64

Ports:
clk_800MHz  input  1  sole clock; all inputs sampled and all state updated on rising edge
reset  input  1  asynchronous, active-low reset; 0 = reset asserted
dataPin_i  input  1  serial sideband data lane
clkActive_i  input  1  level copy of forwarded-clock gating; 1 on cycles the TX clock toggles
enable_i  input  1  receiver enable; 0 forces IDLE and ignores the lane
data_o  output  64  packet at FIFO head
valid_o  output  1  FIFO non-empty
ready_i  input  1  consumer accepts data_o when valid_o && ready_i
overflow_o  output  1  sticky; a completed packet was dropped because the FIFO was full
frame_err_o  output  1  one-cycle pulse on each framing error
gap_err_o  output  1  sticky; dataPin_i was 1 during a gap cycle
err_clr_i  input  1  synchronous clear of overflow_o and gap_err_o

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, bit counter=0, gap counter=0, FIFO empty (read and write pointers 0). data_o=0, valid_o=0, overflow_o=0, frame_err_o=0, gap_err_o=0.
- States: IDLE, RECEIVING, GAP.
- IDLE
  - If enable_i && clkActive_i: the current dataPin_i is captured as bit 0, bit counter=1, go to RECEIVING.
  - Otherwise remain in IDLE.
- RECEIVING
  - Each cycle with clkActive_i=1: shift_reg[bit_ctr] <= dataPin_i, bit_ctr++.
  - On the cycle bit 63 is captured: the packet is complete. Push it the next cycle if the FIFO is not full; otherwise drop it and set overflow_o. Then go to GAP with gap counter=0.
  - clkActive_i=0 or enable_i=0 before bit 63: discard the partial packet, pulse frame_err_o, go to IDLE.
- GAP
  - Counts GAP_CYCLES cycles of clkActive_i=1.
  - dataPin_i=1 on any of those cycles sets gap_err_o.
  - clkActive_i=0 during GAP is legal: go to IDLE with no error.
  - After the final gap cycle: go to RECEIVING if clkActive_i is still 1 (the next cycle carries bit 0), else go to IDLE.
- Latency: valid_o rises 2 cycles after the cycle bit 63 is sampled.
- FIFO behaviour:
  - Pointers are $clog2(buffer_size) bits plus one wrap bit. Full and empty are distinguished by the wrap bit; both pointers wrap naturally.
  - data_o = mem[rd_ptr], combinational from registered storage.
  - Pop when valid_o && ready_i.
  - Simultaneous push and pop when full: the pop frees the entry, so the push succeeds and no overflow is flagged.
  - Simultaneous push and pop when empty: the push is visible next cycle. There is no fall-through.
- err_clr_i clears both sticky flags. If a new error event occurs in the same cycle, the set wins.
- A reset asserted mid-packet or mid-gap aborts immediately. No error flags are raised and FIFO contents are lost.
- enable_i=0 does not flush the FIFO. Draining still works.

Test Plan:
- Single packet: drive 0xDEADBEEF_01234567 LSB first with clkActive_i=1 for 64 cycles, then 32 gap cycles of zeros, ready_i=1 -> valid_o high exactly 2 cycles after bit 63, data_o=0xDEADBEEF_01234567; no flags set.
- Back-to-back: packets 0x1, 0x2, 0x3 with exactly 32-cycle gaps and clkActive_i held high throughout -> three pops in order 0x1, 0x2, 0x3; gap_err_o=0.
- Overflow: ready_i=0, send buffer_size+1=5 packets -> packets 1–4 retained, packet 5 dropped, overflow_o=1; then ready_i=1 -> exactly 4 pops, order preserved; err_clr_i pulse -> overflow_o=0.
- Truncated frame: drop clkActive_i after 40 bits -> frame_err_o is a one-cycle pulse, FIFO unchanged, state IDLE; the next full packet 0xA5A5... is received correctly.
- Gap violation: dataPin_i=1 on gap cycle 10 -> gap_err_o=1 (sticky); the next packet is still accepted.
- Async reset mid-packet: assert reset=0 at bit 20 between clock edges -> all outputs 0 immediately; after release, a full packet 0xFFFF_FFFF_FFFF_FFFF is received correctly.
